alu_iterative: RTL and testbench

Sequential RV32I integer ALU that responds to the operand/funct3 stimulus produced by the ALU-base driver. Operands and operation are captured on an `enable` handshake. Single-cycle ops complete in one cycle. Shifts execute one bit per cycle through a small state machine. It sits between register-file read and write-back, with `done` qualifying `register_data_out`.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_rv_comb.sv | 28 ++
 rtl/alu_iterative.sv | 108 ++++++++++
 tb/tb_alu_iterative.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative RV32I ALU: operand width, funct3 codes, FSM states.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    function automatic logic is_shift(input logic [2:0] f3);
        return (f3 == F3_SLL) || (f3 == F3_SRL);
    endfunction

endpackage

// File: rtl/alu_rv_comb.sv
// Combinational single-cycle RV32I ops (ADD/SUB/SLT/SLTU/XOR/OR/AND).
// Zero latency; no flow control. Shift codes return zero (handled by the iterative datapath).
module alu_rv_comb
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = '0;
        case (funct3)
            F3_ADD:  result = funct7_5 ? (op_a - op_b) : (op_a + op_b);
            F3_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            F3_SLTU: result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            F3_XOR:  result = op_a ^ op_b;
            F3_OR:   result = op_a | op_b;
            F3_AND:  result = op_a & op_b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_iterative.sv
// Sequential RV32I ALU: single-cycle ops finish the cycle after accept; shifts take shamt+1 further edges.
// Requests are accepted only when not busy; requests arriving while busy are dropped, never queued.
module alu_iterative
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            enable,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] register_data_1,
    input  logic [XLEN-1:0] register_data_2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] register_data_out
);

    localparam int SHW = $clog2(XLEN);

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [XLEN-1:0]   work_q, work_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic              left_q, left_d;
    logic              arith_q, arith_d;
    logic [XLEN-1:0]   comb_result;

    alu_rv_comb #(.XLEN(XLEN)) u_comb (
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .op_a     (register_data_1),
        .op_b     (register_data_2),
        .result   (comb_result)
    );

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        arith_d  = arith_q;
        case (state_q)
            S_IDLE: begin
                if (enable && !busy_q) begin
                    if (is_shift(funct3)) begin
                        work_d  = register_data_1;
                        cnt_d   = register_data_2[SHW-1:0];
                        left_d  = (funct3 == F3_SLL);
                        arith_d = (funct3 == F3_SRL) && funct7_5;
                        busy_d  = 1'b1;
                        state_d = S_SHIFT;
                    end else begin
                        result_d = comb_result;
                        done_d   = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (cnt_q != '0) begin
                    // Right shifts fill with the sign bit only for SRA.
                    work_d = left_q ? {work_q[XLEN-2:0], 1'b0}
                                    : {arith_q & work_q[XLEN-1], work_q[XLEN-1:1]};
                    cnt_d  = cnt_q - SHW'(1);
                end else begin
                    result_d = work_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
            arith_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            arith_q  <= arith_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign register_data_out = result_q;

endmodule

// File: tb/tb_alu_iterative.sv
// Directed plus randomized checks of alu_iterative against an arithmetic reference model.
module tb_alu_iterative;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] register_data_1;
    logic [31:0] register_data_2;
    logic        busy;
    logic        done;
    logic [31:0] register_data_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    alu_iterative #(.XLEN(32)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .enable            (enable),
        .funct3            (funct3),
        .funct7_5          (funct7_5),
        .register_data_1   (register_data_1),
        .register_data_2   (register_data_2),
        .busy              (busy),
        .done              (done),
        .register_data_out (register_data_out)
    );

    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic f7,
                                            input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic [31:0] r;
        sa = a;
        r  = 32'h0;
        case (f3)
            3'd0: r = f7 ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: if ($signed(a) < $signed(b)) r = 32'h1;
            3'd3: if (a < b) r = 32'h1;
            3'd4: r = a ^ b;
            3'd5: begin
                if (f7) r = sa >>> b[4:0];
                else    r = a >> b[4:0];
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble inputs after accept, and check latency, busy and result.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic f7,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        int lat;
        int n;
        exp = ref_alu(f3, f7, a, b);
        lat = (f3 == 3'd1 || f3 == 3'd5) ? int'(b[4:0]) + 1 : 0;
        funct3 = f3; funct7_5 = f7; register_data_1 = a; register_data_2 = b; enable = 1'b1;
        tick();
        enable = 1'b0;
        register_data_1 = $urandom; register_data_2 = $urandom;
        funct3 = 3'($urandom); funct7_5 = 1'($urandom);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            chk({tag, "_busy_hi"}, 32'(busy), 32'h1);
            tick();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_busy_lo"}, 32'(busy), 32'h0);
        chk({tag, "_out"}, register_data_out, exp);
    endtask

    initial begin
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] a, b, exp_prev, out_hold;
        int n;

        reset_n = 1'b0; enable = 1'b0; funct3 = 3'd0; funct7_5 = 1'b0;
        register_data_1 = 32'h0; register_data_2 = 32'h0;
        #3;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_out", register_data_out, 32'h0);
        #10 reset_n = 1'b1;
        tick();
        chk("idle_done", 32'(done), 32'h0);

        run_op("add",  3'd0, 1'b0, 32'd1, 32'd2);
        tick();
        chk("add_done_pulse", 32'(done), 32'h0);
        chk("add_out_held", register_data_out, 32'd3);
        run_op("sub",  3'd0, 1'b1, 32'd0, 32'd1);
        run_op("slt",  3'd2, 1'b0, 32'hFFFFFFFF, 32'd1);
        run_op("sltu", 3'd3, 1'b0, 32'hFFFFFFFF, 32'd1);
        run_op("sra4", 3'd5, 1'b1, 32'h80000000, 32'd4);
        run_op("srl4", 3'd5, 1'b0, 32'h80000000, 32'd4);
        run_op("sll0", 3'd1, 1'b0, 32'h1, 32'd0);
        run_op("sll31", 3'd1, 1'b0, 32'h1, 32'd31);
        run_op("shamt_hi_ignored", 3'd5, 1'b1, 32'h8000F000, 32'hFFFFFFE3);

        // Enable held high through a shift: in-flight requests must be dropped.
        funct3 = 3'd1; funct7_5 = 1'b0; register_data_1 = 32'h1; register_data_2 = 32'd8;
        enable = 1'b1;
        tick();
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            chk("hold_busy_hi", 32'(busy), 32'h1);
            register_data_1 = $urandom; register_data_2 = $urandom;
            funct3 = 3'($urandom); funct7_5 = 1'($urandom);
            tick();
            n++;
        end
        chk("hold_lat", 32'(n), 32'd9);
        chk("hold_out", register_data_out, 32'h100);
        funct3 = 3'd0; funct7_5 = 1'b0; register_data_1 = 32'd5; register_data_2 = 32'd7;
        tick();
        chk("after_done_accept_vld", 32'(done), 32'h1);
        chk("after_done_accept_out", register_data_out, 32'd12);

        // Back-to-back single-cycle ops with enable held high.
        exp_prev = 32'h0;
        for (int i = 0; i < 20; i++) begin
            f3 = 3'($urandom);
            if (f3 == 3'd1 || f3 == 3'd5) f3 = 3'd0;
            f7 = 1'($urandom);
            a = $urandom; b = $urandom;
            funct3 = f3; funct7_5 = f7; register_data_1 = a; register_data_2 = b;
            tick();
            chk("b2b_done", 32'(done), 32'h1);
            chk("b2b_out", register_data_out, ref_alu(f3, f7, a, b));
            exp_prev = register_data_out;
        end
        enable = 1'b0;
        tick();
        chk("b2b_end_done", 32'(done), 32'h0);
        chk("b2b_end_hold", register_data_out, ref_alu(f3, f7, a, b));

        for (int i = 0; i < 30; i++) begin
            f3 = 3'($urandom);
            f7 = 1'($urandom);
            a = (i % 5 == 0) ? 32'h80000001 : $urandom;
            b = $urandom;
            run_op("rand", f3, f7, a, b);
        end

        // Reset in the middle of a 10-step shift aborts the op.
        out_hold = register_data_out;
        funct3 = 3'd5; funct7_5 = 1'b1; register_data_1 = 32'hF0000000; register_data_2 = 32'd10;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        chk("abort_busy_pre", 32'(busy), 32'h1);
        chk("abort_out_pre", register_data_out, out_hold);
        tick(); tick(); tick();
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_out", register_data_out, 32'h0);
        #3 reset_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("abort_no_late_done", 32'(done), 32'h0);
            chk("abort_no_busy", 32'(busy), 32'h0);
        end
        chk("abort_out_after", register_data_out, 32'h0);
        run_op("post_abort_add", 3'd0, 1'b0, 32'h7FFFFFFF, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
